// File: rtl/shot_spawner.sv
// shot_spawner: periodically launches shots at a random x column, advances
// live shots by SPEED rows per accepted frame, retires escaped or hit shots.
// Per-slot position state lives in shot_slot; the sequencing FSM walks the
// slot table one entry per cycle and then optionally spawns a new shot.

// One shot slot: holds live bit and x/y, applies load, hit and move requests.
module shot_slot #(
    parameter int SPEED   = 4,
    parameter int Y_START = 0,
    parameter int Y_LIMIT = 479
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move,
    input  logic       load,
    input  logic       hit,
    input  logic [8:0] load_x,
    output logic       active,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       esc
);
    logic [9:0] y_next;

    // 10-bit sum so a shot near the bottom cannot wrap back to the top
    assign y_next = {1'b0, y} + 10'(SPEED);
    // a hit in the same cycle as the move suppresses the escape
    assign esc    = move && active && !hit && (y_next > 10'(Y_LIMIT));

    // Load only targets an inactive slot, so a concurrent hit is a no-op there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else if (load) begin
            active <= 1'b1;
            x      <= load_x;
            y      <= 9'(Y_START);
        end else if (hit) begin
            active <= 1'b0;
        end else if (move && active) begin
            if (y_next > 10'(Y_LIMIT)) active <= 1'b0;
            else                       y      <= y_next[8:0];
        end
    end
endmodule

module shot_spawner #(
    parameter int NUM_SHOTS    = 4,
    parameter int SPAWN_PERIOD = 90,
    parameter int SPEED        = 4,
    parameter int Y_START      = 0,
    parameter int Y_LIMIT      = 479,
    parameter int X_MAX        = 400
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         frame_tick,
    input  logic [8:0]                   random_value,
    input  logic                         hit_valid,
    input  logic [$clog2(NUM_SHOTS)-1:0] hit_slot,
    output logic [NUM_SHOTS-1:0]         shot_active,
    output logic [NUM_SHOTS*9-1:0]       shot_x,
    output logic [NUM_SHOTS*9-1:0]       shot_y,
    output logic                         spawn_pulse,
    output logic                         escaped,
    output logic [7:0]                   drop_count,
    output logic                         busy
);
    localparam int IW = $clog2(NUM_SHOTS);
    localparam int CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        frame_cnt;
    logic                 spawn_due;
    logic [NUM_SHOTS-1:0] move_sel;
    logic [NUM_SHOTS-1:0] hit_sel;
    logic [NUM_SHOTS-1:0] load_sel;
    logic [NUM_SHOTS-1:0] esc_vec;
    logic                 free_any;
    logic [IW-1:0]        free_idx;
    logic [8:0]           clamp_x;

    assign clamp_x = (random_value > 9'(X_MAX)) ? 9'(X_MAX) : random_value;

    // Lowest-index free slot from the registered active vector
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!shot_active[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        // hit_slot values past the table never match a slot and fall away
        assign move_sel[g] = (state == MOVE) && (idx == IW'(g));
        assign hit_sel[g]  = hit_valid && (hit_slot == IW'(g));
        assign load_sel[g] = (state == SPAWN) && free_any && (free_idx == IW'(g));

        shot_slot #(
            .SPEED   (SPEED),
            .Y_START (Y_START),
            .Y_LIMIT (Y_LIMIT)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .move   (move_sel[g]),
            .load   (load_sel[g]),
            .hit    (hit_sel[g]),
            .load_x (clamp_x),
            .active (shot_active[g]),
            .x      (shot_x[9*g +: 9]),
            .y      (shot_y[9*g +: 9]),
            .esc    (esc_vec[g])
        );
    end

    // Sequencer: accept tick, walk slots, optional spawn; all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            frame_cnt   <= '0;
            spawn_due   <= 1'b0;
            spawn_pulse <= 1'b0;
            escaped     <= 1'b0;
            drop_count  <= '0;
            busy        <= 1'b0;
        end else begin
            spawn_pulse <= 1'b0;
            escaped     <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && frame_tick) begin
                        state <= MOVE;
                        idx   <= '0;
                        busy  <= 1'b1;
                        if (frame_cnt == CW'(SPAWN_PERIOD - 1)) begin
                            frame_cnt <= '0;
                            spawn_due <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                end
                MOVE: begin
                    escaped <= |esc_vec;
                    if (idx == IW'(NUM_SHOTS - 1)) begin
                        if (spawn_due) begin
                            state <= SPAWN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                SPAWN: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    spawn_due   <= 1'b0;
                    spawn_pulse <= free_any;
                    if (!free_any && drop_count != 8'hFF)
                        drop_count <= drop_count + 8'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shot_spawner.sv
// Bench for shot_spawner: frame-level reference model pushes expected end-of-
// frame state to a queue; a monitor pops and compares when busy drops.
// Instance 0 uses Y_LIMIT=12 (exit behaviour), instance 1 uses 479 (fill-up).
module tb_shot_spawner;
    localparam int SP = 2;

    logic        clk = 0;
    logic        reset = 0;
    logic [1:0]  en = '0;
    logic        frame_tick = 0;
    logic [8:0]  rv = '0;
    logic [1:0]  hv = '0;
    logic [1:0]  hs = '0;
    logic [3:0]  act [2];
    logic [35:0] sx [2];
    logic [35:0] sy [2];
    logic [1:0]  spawn_pulse, escaped, busy;
    logic [7:0]  drop [2];

    typedef struct {
        int          inst;
        logic [3:0]  act;
        logic [35:0] x;
        logic [35:0] y;
        int          drop;
        int          nsp;
        int          nesc;
        int          nbusy;
    } rec_t;

    rec_t        q[$];
    int          n_chk = 0, n_fail = 0;
    logic [3:0]  m_act [2];
    logic [35:0] m_x [2];
    logic [35:0] m_y [2];
    int          m_cnt [2];
    int          m_drop [2];
    int          ylim [2] = '{12, 479};

    always #5 clk = ~clk;

    shot_spawner #(.NUM_SHOTS(4), .SPAWN_PERIOD(SP), .SPEED(4), .Y_START(0),
                   .Y_LIMIT(12), .X_MAX(400)) dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .frame_tick(frame_tick),
        .random_value(rv), .hit_valid(hv[0]), .hit_slot(hs),
        .shot_active(act[0]), .shot_x(sx[0]), .shot_y(sy[0]),
        .spawn_pulse(spawn_pulse[0]), .escaped(escaped[0]),
        .drop_count(drop[0]), .busy(busy[0]));

    shot_spawner #(.NUM_SHOTS(4), .SPAWN_PERIOD(SP), .SPEED(4), .Y_START(0),
                   .Y_LIMIT(479), .X_MAX(400)) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .frame_tick(frame_tick),
        .random_value(rv), .hit_valid(hv[1]), .hit_slot(hs),
        .shot_active(act[1]), .shot_x(sx[1]), .shot_y(sy[1]),
        .spawn_pulse(spawn_pulse[1]), .escaped(escaped[1]),
        .drop_count(drop[1]), .busy(busy[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = '0; m_x[i] = '0; m_y[i] = '0; m_cnt[i] = 0; m_drop[i] = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_act"}, 64'(act[i]), 0);
            chk({tag, "_x"}, 64'(sx[i]), 0);
            chk({tag, "_y"}, 64'(sy[i]), 0);
            chk({tag, "_drop"}, 64'(drop[i]), 0);
            chk({tag, "_flags"}, 64'({spawn_pulse[i], escaped[i], busy[i]}), 0);
        end
    endtask

    // One accepted frame on instance inst. At MOVE index k (4 = SPAWN cycle)
    // optionally: hit slot hslot, re-pulse frame_tick, or drop enable.
    task automatic frame(input int inst, input int k, input bit hit, input int hslot,
                         input bit xtick, input bit dis);
        rec_t r;
        bit due = 0;
        int esc = 0, sp = 0, sel = -1;
        logic [9:0] ny;
        if (m_cnt[inst] == SP - 1) begin m_cnt[inst] = 0; due = 1; end
        else m_cnt[inst]++;
        for (int s = 0; s < 4; s++) begin
            if (hit && hslot == s && k < 4 && s >= k) begin
                m_act[inst][s] = 1'b0;
            end else begin
                if (m_act[inst][s]) begin
                    ny = {1'b0, m_y[inst][9*s +: 9]} + 10'd4;
                    if (int'(ny) > ylim[inst]) begin m_act[inst][s] = 1'b0; esc++; end
                    else m_y[inst][9*s +: 9] = ny[8:0];
                end
                if (hit && hslot == s && k < 4) m_act[inst][s] = 1'b0;
            end
        end
        if (due) for (int s = 3; s >= 0; s--) if (!m_act[inst][s]) sel = s;
        if (hit && k >= 4) m_act[inst][hslot] = 1'b0;
        if (due) begin
            if (sel >= 0) begin
                m_act[inst][sel] = 1'b1;
                m_x[inst][9*sel +: 9] = (rv > 9'd400) ? 9'd400 : rv;
                m_y[inst][9*sel +: 9] = 9'd0;
                sp = 1;
            end else if (m_drop[inst] < 255) begin
                m_drop[inst]++;
            end
        end
        r.inst = inst; r.act = m_act[inst]; r.x = m_x[inst]; r.y = m_y[inst];
        r.drop = m_drop[inst]; r.nsp = sp; r.nesc = esc; r.nbusy = due ? 5 : 4;
        q.push_back(r);

        @(posedge clk); #1 frame_tick = 1;
        @(posedge clk); #1 frame_tick = 0;
        repeat (k) @(posedge clk);
        #1;
        hv[inst] = hit; hs = 2'(hslot); frame_tick = xtick;
        if (dis) en[inst] = 1'b0;
        @(posedge clk); #1;
        hv = '0; frame_tick = 0;
        repeat (6) @(posedge clk);
        #1 en[inst] = 1'b1;
        chk("drain", 64'(q.size()), 0);
    endtask

    // Monitor: count pulses/busy cycles per frame, compare when busy falls
    initial begin
        rec_t r;
        bit pb [2] = '{0, 0};
        int cb [2] = '{0, 0};
        int cs [2] = '{0, 0};
        int ce [2] = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    pb[i] = 0; cb[i] = 0; cs[i] = 0; ce[i] = 0;
                end else begin
                    if (busy[i]) cb[i]++;
                    if (spawn_pulse[i]) cs[i]++;
                    if (escaped[i]) ce[i]++;
                    if (pb[i] && !busy[i]) begin
                        if (q.size() == 0) begin
                            chk("unexpected_frame", 1, 0);
                        end else begin
                            r = q.pop_front();
                            chk("inst", 64'(i), 64'(r.inst));
                            chk("active", 64'(act[i]), 64'(r.act));
                            for (int s = 0; s < 4; s++) if (r.act[s]) begin
                                chk("x", 64'(sx[i][9*s +: 9]), 64'(r.x[9*s +: 9]));
                                chk("y", 64'(sy[i][9*s +: 9]), 64'(r.y[9*s +: 9]));
                            end
                            chk("drop_count", 64'(drop[i]), 64'(r.drop));
                            chk("spawn_pulses", 64'(cs[i]), 64'(r.nsp));
                            chk("escaped_pulses", 64'(ce[i]), 64'(r.nesc));
                            chk("busy_cycles", 64'(cb[i]), 64'(r.nbusy));
                        end
                        cb[i] = 0; cs[i] = 0; ce[i] = 0;
                    end
                    pb[i] = busy[i];
                end
            end
        end
    end

    initial begin
        model_reset();
        // reset held with random inputs
        repeat (6) begin
            @(posedge clk); #1;
            en = 2'($urandom); frame_tick = 1'($urandom); rv = 9'($urandom);
            hv = 2'($urandom); hs = 2'($urandom);
            @(negedge clk);
            chk_all_zero("reset_hold");
        end
        @(posedge clk); #1;
        en = '0; frame_tick = 0; hv = '0; hs = '0; rv = '0;
        reset = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        // instance 0: first spawn, movement and exit through Y_LIMIT=12
        en = 2'b01; rv = 9'd123;
        for (int f = 0; f < 8; f++) frame(0, 0, 0, 0, 0, 0);

        // instance 1: fill table, ignored tick, enable drop, hits
        en = 2'b10;
        for (int f = 1; f <= 10; f++) begin
            rv = 9'($urandom_range(0, 511));
            if (f == 3)      frame(1, 2, 0, 0, 1, 0);   // tick while busy
            else if (f == 5) frame(1, 1, 0, 0, 0, 1);   // enable falls mid-move
            else             frame(1, 0, 0, 0, 0, 0);
        end
        rv = 9'd77;
        frame(1, 1, 1, 1, 0, 0);    // hit slot 1 while MOVE processes it
        frame(1, 0, 0, 0, 0, 0);    // spawn refills slot 1
        frame(1, 0, 0, 0, 0, 0);
        frame(1, 4, 1, 2, 0, 0);    // table full: drop, hit slot 2 in SPAWN
        rv = 9'd511;
        frame(1, 0, 0, 0, 0, 0);
        frame(1, 4, 1, 3, 0, 0);    // x clamps to 400 in slot 2, hit slot 3
        rv = 9'd300;
        frame(1, 0, 0, 0, 0, 0);
        frame(1, 4, 1, 3, 0, 0);    // hit on the slot being spawned is a no-op

        // instance 0: reset during MOVE idx=2
        en = 2'b01; rv = 9'd511;
        @(posedge clk); #1 frame_tick = 1;
        @(posedge clk); #1 frame_tick = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        #1 chk_all_zero("reset_mid");
        model_reset();
        @(posedge clk); #1 reset = 1;
        frame(0, 0, 0, 0, 0, 0);    // no spawn yet
        frame(0, 0, 0, 0, 0, 0);    // spawn with clamped x

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
